// File: rtl/seven_seg_frame_driver_pkg.sv
// rtl/seven_seg_frame_driver_pkg.sv - shared seven-segment encodings and hex decode function
package seven_seg_pkg;

  localparam int NUM_DIGITS = 4;

  // Active-low segment pattern {g,f,e,d,c,b,a} with every segment dark
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Active-low anode enables; index is the digit number, digit0 rightmost
  localparam logic [3:0] ANODE_OFF = 4'b1111;
  localparam logic [3:0] ANODE_SEL [NUM_DIGITS] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  // Hex nibble to active-low {g,f,e,d,c,b,a}
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seven_seg_frame_driver_if.sv
// rtl/seven_seg_frame_driver_if.sv - frame valid/ready handshake bundle
interface seven_seg_frame_if;
  import seven_seg_pkg::*;

  logic                      frame_valid;
  logic                      frame_ready;
  logic [NUM_DIGITS*4-1:0]   frame_data;
  logic [NUM_DIGITS-1:0]     frame_dp;
  logic                      frame_lz;

  modport master (
    output frame_valid, frame_data, frame_dp, frame_lz,
    input  frame_ready
  );

  modport slave (
    input  frame_valid, frame_data, frame_dp, frame_lz,
    output frame_ready
  );

endinterface

// File: rtl/seven_seg_frame_driver_hex_decode.sv
// rtl/seven_seg_frame_driver_hex_decode.sv - combinational nibble to seven-segment decoder
module seven_seg_hex_decode
  import seven_seg_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  // Pure lookup so other display blocks share exactly the same glyphs
  always_comb begin
    o_seg = hex_to_seg(i_nibble);
  end

endmodule

// File: rtl/seven_seg_frame_driver.sv
// rtl/seven_seg_frame_driver.sv - double-buffered 4-digit seven-segment scan driver
module seven_seg_frame_driver
  import seven_seg_pkg::*;
#(
  parameter int TICK_DIV  = 100000,
  parameter int BLANK_CYC = 16
) (
  input  logic                clk,
  input  logic                reset,
  seven_seg_frame_if.slave    frame,
  output logic [3:0]          anode,
  output logic [6:0]          cathode,
  output logic                dp
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] PRESC_MAX = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_presc;
  logic [1:0]    r_idx;

  logic          r_pend_full;
  logic [15:0]   r_pend_data;
  logic [3:0]    r_pend_dp;
  logic          r_pend_lz;

  logic [15:0]   r_act_data;
  logic [3:0]    r_act_dp;
  logic          r_act_lz;

  logic [3:0]    r_anode;
  logic [6:0]    r_cathode;
  logic          r_dp;

  logic          w_tick;
  logic          w_swap;
  logic          w_accept;
  logic [CW-1:0] w_presc_next;
  logic [1:0]    w_idx_next;
  logic [15:0]   w_act_data_next;
  logic [3:0]    w_act_dp_next;
  logic          w_act_lz_next;
  logic [3:0]    w_nibble;
  logic [3:0]    w_lead_zero;
  logic          w_suppress;
  logic          w_blank;
  logic [6:0]    w_seg;

  assign frame.frame_ready = ~r_pend_full;

  // Scan timing, swap/accept decisions and the next-slot display selection.
  // Outputs are computed from next-state values so the registered pins change
  // in the cycle right after scan_tick and already show a freshly swapped frame.
  always_comb begin
    w_tick          = (r_presc == PRESC_MAX);
    w_presc_next    = w_tick ? '0 : r_presc + CW'(1);
    w_idx_next      = w_tick ? r_idx + 2'd1 : r_idx;
    w_swap          = w_tick & (r_idx == 2'd3) & r_pend_full;
    w_accept        = frame.frame_valid & ~r_pend_full;
    w_act_data_next = w_swap ? r_pend_data : r_act_data;
    w_act_dp_next   = w_swap ? r_pend_dp   : r_act_dp;
    w_act_lz_next   = w_swap ? r_pend_lz   : r_act_lz;
    w_nibble        = w_act_data_next[w_idx_next*4 +: 4];
    // A digit is a leading zero when it and every digit to its left are zero
    w_lead_zero[3]  = (w_act_data_next[15:12] == 4'h0);
    w_lead_zero[2]  = (w_act_data_next[11:8]  == 4'h0) & w_lead_zero[3];
    w_lead_zero[1]  = (w_act_data_next[7:4]   == 4'h0) & w_lead_zero[2];
    w_lead_zero[0]  = 1'b0;
    w_suppress      = w_act_lz_next & w_lead_zero[w_idx_next];
    w_blank         = (32'(w_presc_next) < 32'(BLANK_CYC));
  end

  seven_seg_hex_decode u_decode (
    .i_nibble (w_nibble),
    .o_seg    (w_seg)
  );

  // Prescaler and digit index
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_presc <= '0;
      r_idx   <= 2'd0;
    end else begin
      r_presc <= w_presc_next;
      r_idx   <= w_idx_next;
    end
  end

  // Pending buffer: filled by the handshake, drained only at the frame boundary
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pend_full <= 1'b0;
      r_pend_data <= 16'h0000;
      r_pend_dp   <= 4'b0000;
      r_pend_lz   <= 1'b0;
    end else if (w_swap) begin
      r_pend_full <= 1'b0;
    end else if (w_accept) begin
      r_pend_full <= 1'b1;
      r_pend_data <= frame.frame_data;
      r_pend_dp   <= frame.frame_dp;
      r_pend_lz   <= frame.frame_lz;
    end
  end

  // Active frame: replaced only when a full pending frame meets the index-3 tick
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_act_data <= 16'h0000;
      r_act_dp   <= 4'b0000;
      r_act_lz   <= 1'b0;
    end else if (w_swap) begin
      r_act_data <= r_pend_data;
      r_act_dp   <= r_pend_dp;
      r_act_lz   <= r_pend_lz;
    end
  end

  // Registered pins; anodes stay dark for the first BLANK_CYC cycles of a slot
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_anode   <= ANODE_OFF;
      r_cathode <= SEG_BLANK;
      r_dp      <= 1'b1;
    end else begin
      r_anode   <= w_blank ? ANODE_OFF : ANODE_SEL[w_idx_next];
      r_cathode <= w_suppress ? SEG_BLANK : w_seg;
      r_dp      <= ~w_act_dp_next[w_idx_next];
    end
  end

  assign anode   = r_anode;
  assign cathode = r_cathode;
  assign dp      = r_dp;

endmodule

// File: tb/tb_seven_seg_frame_driver.sv
// tb/tb_seven_seg_frame_driver.sv - directed self-checking bench for seven_seg_frame_driver
module tb_seven_seg_frame_driver;

  logic       clk;
  logic       reset;
  logic [3:0] anode;
  logic [6:0] cathode;
  logic       dp;
  int         errors;
  int         checks;
  int         n;

  seven_seg_frame_if frame_if ();

  seven_seg_frame_driver #(.TICK_DIV(4), .BLANK_CYC(1)) dut (
    .clk     (clk),
    .reset   (reset),
    .frame   (frame_if),
    .anode   (anode),
    .cathode (cathode),
    .dp      (dp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycles since reset release; prescaler == n%4 and index == (n/4)%4
  always @(posedge clk or negedge reset) begin
    if (!reset) n <= 0;
    else        n <= n + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h (n=%0d)", tag, got, exp, n);
    end
  endtask

  task automatic goto_n(input int t);
    int guard = 0;
    while (n < t && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (n != t) check_val("goto_n", 16'(n), 16'(t));
  endtask

  task automatic load(input logic [15:0] d, input logic [3:0] p, input logic z);
    frame_if.frame_valid = 1'b1;
    frame_if.frame_data  = d;
    frame_if.frame_dp    = p;
    frame_if.frame_lz    = z;
    @(negedge clk);
    frame_if.frame_valid = 1'b0;
  endtask

  // segs = {d3,d2,d1,d0} cathodes, dpn = expected active-low dp pins [3:0]
  task automatic frame_check(input int base, input logic [27:0] segs, input logic [3:0] dpn);
    logic [3:0] ea;
    for (int d = 0; d < 4; d++) begin
      goto_n(base + 4*d);
      check_val($sformatf("blank_an_d%0d", d), 16'(anode), 16'(4'b1111));
      check_val($sformatf("cath_d%0d", d), 16'(cathode), 16'(segs[7*d +: 7]));
      check_val($sformatf("dp_d%0d", d), 16'(dp), 16'(dpn[d]));
      goto_n(base + 4*d + 1);
      ea = ~(4'b0001 << d);
      check_val($sformatf("an_d%0d", d), 16'(anode), 16'(ea));
    end
  endtask

  initial begin
    logic [3:0] ea;
    errors = 0;
    checks = 0;
    reset = 1'b0;
    frame_if.frame_valid = 1'b0;
    frame_if.frame_data  = 16'h0000;
    frame_if.frame_dp    = 4'b0000;
    frame_if.frame_lz    = 1'b0;

    // 1. reset values
    repeat (3) @(negedge clk);
    check_val("rst_anode", 16'(anode), 16'(4'b1111));
    check_val("rst_cathode", 16'(cathode), 16'(7'b1111111));
    check_val("rst_dp", 16'(dp), 16'(1'b1));
    reset = 1'b1;
    #1;
    check_val("rst_ready", 16'(frame_if.frame_ready), 16'(1'b1));
    @(negedge clk);
    check_val("first_ready", 16'(frame_if.frame_ready), 16'(1'b1));
    check_val("first_anode", 16'(anode), 16'(4'b1110));
    check_val("first_cath", 16'(cathode), 16'(7'b1000000));

    // 2. frame 1234, dp on digit1
    load(16'h1234, 4'b0010, 1'b0);
    check_val("pend_ready", 16'(frame_if.frame_ready), 16'(1'b0));
    goto_n(15);
    check_val("preswap_ready", 16'(frame_if.frame_ready), 16'(1'b0));
    check_val("preswap_cath", 16'(cathode), 16'(7'b1000000));
    check_val("preswap_an", 16'(anode), 16'(4'b0111));
    goto_n(16);
    check_val("postswap_ready", 16'(frame_if.frame_ready), 16'(1'b1));
    frame_check(16, {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}, 4'b1101);
    frame_check(32, {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}, 4'b1101);

    // 3. back-to-back AAAA then 5555 with valid held
    goto_n(45);
    frame_if.frame_valid = 1'b1;
    frame_if.frame_data  = 16'hAAAA;
    frame_if.frame_dp    = 4'b0000;
    frame_if.frame_lz    = 1'b0;
    @(negedge clk);
    frame_if.frame_data  = 16'h5555;
    check_val("b2b_stall0", 16'(frame_if.frame_ready), 16'(1'b0));
    goto_n(47);
    check_val("b2b_stall1", 16'(frame_if.frame_ready), 16'(1'b0));
    goto_n(48);
    check_val("b2b_ready", 16'(frame_if.frame_ready), 16'(1'b1));
    check_val("b2b_cathA", 16'(cathode), 16'(7'b0001000));
    @(negedge clk);
    frame_if.frame_valid = 1'b0;
    check_val("b2b_pend", 16'(frame_if.frame_ready), 16'(1'b0));
    goto_n(63);
    check_val("b2b_stillA", 16'(cathode), 16'(7'b0001000));
    goto_n(64);
    check_val("b2b_cath5", 16'(cathode), 16'(7'b0010010));
    check_val("b2b_ready2", 16'(frame_if.frame_ready), 16'(1'b1));

    // 4. leading-zero suppression on 0050, then same frame without it
    load(16'h0050, 4'b1000, 1'b1);
    frame_check(80, {7'b1111111, 7'b1111111, 7'b0010010, 7'b1000000}, 4'b0111);
    load(16'h0050, 4'b0000, 1'b0);
    frame_check(96, {7'b1000000, 7'b1000000, 7'b0010010, 7'b1000000}, 4'b1111);

    // 5. pending frame discarded by reset mid-frame
    load(16'h8888, 4'b1111, 1'b0);
    check_val("r5_pend", 16'(frame_if.frame_ready), 16'(1'b0));
    goto_n(112);
    frame_if.frame_valid = 1'b1;
    reset = 1'b0;
    @(negedge clk);
    check_val("r5_anode", 16'(anode), 16'(4'b1111));
    check_val("r5_cath", 16'(cathode), 16'(7'b1111111));
    check_val("r5_dp", 16'(dp), 16'(1'b1));
    frame_if.frame_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_val("r5_ready", 16'(frame_if.frame_ready), 16'(1'b1));
    goto_n(4);
    check_val("r5_cath0", 16'(cathode), 16'(7'b1000000));
    check_val("r5_dp0", 16'(dp), 16'(1'b1));
    goto_n(16);
    check_val("r5_noswap", 16'(cathode), 16'(7'b1000000));
    check_val("r5_ready2", 16'(frame_if.frame_ready), 16'(1'b1));

    // 6. long run: anode pattern every cycle across 100+ slots
    for (int k = 17; k < 440; k++) begin
      goto_n(k);
      ea = ((k % 4) == 0) ? 4'b1111 : ~(4'b0001 << ((k / 4) % 4));
      check_val("run_anode", 16'(anode), 16'(ea));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
